// File: rtl/ifetch_queue_pkg.sv
// Shared definitions for the instruction-fetch front end: default widths,
// reset PC and the {pc, inst} queue entry layout.
package if_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int ILEN_DEF   = 32;
    localparam int INST_BYTES = 4;

    localparam logic [XLEN_DEF-1:0] RESET_PC_DEF = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        logic [ILEN_DEF-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/ifetch_queue_if.sv
// Fetch-unit bus: redirect input, instruction-ROM request/response and the
// decode-side valid/ready queue head.
interface ifetch_queue_if #(
    parameter int XLEN  = 32,
    parameter int ILEN  = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic            branch_taken_i;
    logic [XLEN-1:0] branch_addr_i;
    logic            imem_req_o;
    logic [XLEN-1:0] imem_addr_o;
    logic [ILEN-1:0] imem_data_i;
    logic            valid_o;
    logic            ready_i;
    logic [XLEN-1:0] pc_o;
    logic [ILEN-1:0] inst_o;
    logic [CW-1:0]   count_o;

    modport master (
        input  branch_taken_i, branch_addr_i, imem_data_i, ready_i,
        output imem_req_o, imem_addr_o, valid_o, pc_o, inst_o, count_o
    );

    modport slave (
        output branch_taken_i, branch_addr_i, imem_data_i, ready_i,
        input  imem_req_o, imem_addr_o, valid_o, pc_o, inst_o, count_o
    );

endinterface

// File: rtl/ifetch_queue_fifo.sv
// DEPTH-entry synchronous FIFO with flush; occupancy kept in a count register,
// pointers wrap naturally because DEPTH is a power of two.
module ifq_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             m_clock,
    input  logic             p_reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic [CW-1:0]    o_count,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    // A push into a full queue is accepted only when the head leaves the same cycle.
    assign w_do_push = i_push & (~o_full | i_pop);
    assign w_do_pop  = i_pop & ~o_empty;

    always_ff @(posedge m_clock or posedge p_reset) begin
        if (p_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: PC generation, credit-controlled ROM requests,
// in-flight tracking and a decoupling queue, with branch redirect flushing all.
module ifetch_queue
    import if_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter int              ILEN     = ILEN_DEF,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
    input logic            m_clock,
    input logic            p_reset,
    ifetch_queue_if.master bus
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0]      r_pc;
    logic [XLEN-1:0]      r_shadow_pc;
    logic                 r_inflight;

    logic                 w_branch;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_req;
    logic [CW:0]          w_occ;
    logic [CW-1:0]        w_count;
    logic                 w_full;
    logic                 w_empty;
    logic [XLEN+ILEN-1:0] w_rdata;

    assign w_branch = bus.branch_taken_i;
    assign w_pop    = ~w_empty & bus.ready_i;
    // Responses landing in a redirect cycle belong to the old path and are dropped.
    assign w_push   = r_inflight & ~w_branch & (~w_full | w_pop);

    // Occupancy after this cycle counting the outstanding response; a pop
    // implies count >= 1 so the subtraction cannot underflow.
    assign w_occ = {1'b0, w_count} + (CW+1)'(r_inflight) - (CW+1)'(w_pop);
    assign w_req = ~p_reset & ~w_branch & (w_occ < (CW+1)'(DEPTH));

    always_ff @(posedge m_clock or posedge p_reset) begin
        if (p_reset) begin
            r_pc        <= RESET_PC;
            r_shadow_pc <= RESET_PC;
            r_inflight  <= 1'b0;
        end else if (w_branch) begin
            r_pc       <= {bus.branch_addr_i[XLEN-1:2], 2'b00};
            r_inflight <= 1'b0;
        end else if (w_req) begin
            r_pc        <= r_pc + XLEN'(INST_BYTES);
            r_shadow_pc <= r_pc;
            r_inflight  <= 1'b1;
        end else begin
            r_inflight <= 1'b0;
        end
    end

    ifq_fifo #(
        .WIDTH (XLEN + ILEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .m_clock (m_clock),
        .p_reset (p_reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_branch),
        .i_wdata ({r_shadow_pc, bus.imem_data_i}),
        .o_rdata (w_rdata),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign bus.imem_req_o  = w_req;
    assign bus.imem_addr_o = r_pc;
    assign bus.valid_o     = ~w_empty;
    assign bus.pc_o        = w_rdata[XLEN+ILEN-1:ILEN];
    assign bus.inst_o      = w_rdata[ILEN-1:0];
    assign bus.count_o     = w_count;

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: reset, streaming, back-pressure, redirects,
// address alignment, PC wrap and mid-stream reset.
module tb_ifetch_queue;

    localparam int XLEN  = 32;
    localparam int ILEN  = 32;
    localparam int DEPTH = 4;

    logic m_clock = 1'b0;
    logic p_reset = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 m_clock = ~m_clock;

    ifetch_queue_if #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH)) bus ();

    ifetch_queue #(
        .XLEN     (XLEN),
        .ILEN     (ILEN),
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0)
    ) dut (
        .m_clock (m_clock),
        .p_reset (p_reset),
        .bus     (bus)
    );

    function automatic logic [31:0] rom(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // One-cycle-latency ROM
    logic [ILEN-1:0] rom_q = '0;
    always @(posedge m_clock) if (bus.imem_req_o) rom_q <= rom(bus.imem_addr_o);
    assign bus.imem_data_i = rom_q;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge m_clock);
        #1;
    endtask

    initial begin
        logic [31:0] exp_pc;
        bus.branch_taken_i = 1'b0;
        bus.branch_addr_i  = '0;
        bus.ready_i        = 1'b1;

        step(); step();
        chk("rst_valid", bus.valid_o, 0);
        chk("rst_req",   bus.imem_req_o, 0);
        chk("rst_count", bus.count_o, 0);
        chk("rst_addr",  bus.imem_addr_o, 32'h0);
        chk("rst_pc",    bus.pc_o, 0);
        chk("rst_inst",  bus.inst_o, 0);

        // Cycle 0: first cycle out of reset
        p_reset = 1'b0;
        #1;
        chk("c0_req",   bus.imem_req_o, 1);
        chk("c0_addr",  bus.imem_addr_o, 32'h0);
        chk("c0_valid", bus.valid_o, 0);
        step();
        chk("c1_valid", bus.valid_o, 0);
        chk("c1_addr",  bus.imem_addr_o, 32'h4);
        step();
        chk("c2_valid", bus.valid_o, 1);
        chk("c2_pc",    bus.pc_o, 32'h0);
        chk("c2_inst",  bus.inst_o, rom(32'h0));
        for (int k = 3; k <= 4; k++) begin
            step();
            chk("stream_pc",    bus.pc_o, 32'(4 * (k - 2)));
            chk("stream_inst",  bus.inst_o, rom(32'(4 * (k - 2))));
            chk("stream_count", bus.count_o, 1);
        end

        // Back-pressure for 8 cycles: queue fills to DEPTH, requests stop
        step();
        bus.ready_i = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) step();
            chk("hold_valid", bus.valid_o, 1);
            chk("hold_pc",    bus.pc_o, 32'd12);
            chk("hold_inst",  bus.inst_o, rom(32'd12));
            if (i >= 3) begin
                chk("full_count", bus.count_o, 4);
                chk("full_req",   bus.imem_req_o, 0);
            end
        end

        // Resume: contiguous PCs with no gap or duplicate
        step();
        bus.ready_i = 1'b1;
        #1;
        exp_pc = 32'd12;
        for (int j = 0; j < 6; j++) begin
            if (j > 0) step();
            chk("resume_valid", bus.valid_o, 1);
            chk("resume_pc",    bus.pc_o, exp_pc);
            chk("resume_inst",  bus.inst_o, rom(exp_pc));
            exp_pc = exp_pc + 4;
        end

        // Branch with pop and in-flight response outstanding
        step();
        chk("pre_br_count", bus.count_o, 3);
        bus.branch_taken_i = 1'b1;
        bus.branch_addr_i  = 32'd40;
        #1;
        chk("br_req", bus.imem_req_o, 0);
        step();
        bus.branch_taken_i = 1'b0;
        #1;
        chk("br1_count", bus.count_o, 0);
        chk("br1_valid", bus.valid_o, 0);
        chk("br1_req",   bus.imem_req_o, 1);
        chk("br1_addr",  bus.imem_addr_o, 32'd40);
        step();
        chk("br2_valid", bus.valid_o, 0);
        chk("br2_addr",  bus.imem_addr_o, 32'd44);
        step();
        chk("br3_valid", bus.valid_o, 1);
        chk("br3_pc",    bus.pc_o, 32'd40);
        chk("br3_inst",  bus.inst_o, rom(32'd40));
        step();
        chk("br4_pc", bus.pc_o, 32'd44);
        step();
        chk("br5_pc", bus.pc_o, 32'd48);

        // Fill queue, then branch to unaligned 43 while popping a full queue
        step();
        bus.ready_i = 1'b0;
        #1;
        repeat (5) step();
        chk("fill_count", bus.count_o, 4);
        chk("fill_req",   bus.imem_req_o, 0);
        bus.ready_i        = 1'b1;
        bus.branch_taken_i = 1'b1;
        bus.branch_addr_i  = 32'd43;
        #1;
        chk("fbr_valid", bus.valid_o, 1);
        chk("fbr_req",   bus.imem_req_o, 0);
        step();
        bus.branch_taken_i = 1'b0;
        #1;
        chk("fbr1_count", bus.count_o, 0);
        chk("fbr1_valid", bus.valid_o, 0);
        chk("fbr1_addr",  bus.imem_addr_o, 32'd40);
        chk("fbr1_req",   bus.imem_req_o, 1);
        step();
        chk("fbr2_valid", bus.valid_o, 0);
        step();
        chk("fbr3_valid", bus.valid_o, 1);
        chk("fbr3_pc",    bus.pc_o, 32'd40);

        // PC wrap from the top of the address space
        step();
        bus.branch_taken_i = 1'b1;
        bus.branch_addr_i  = 32'hFFFF_FFFC;
        #1;
        step();
        bus.branch_taken_i = 1'b0;
        #1;
        chk("wrap1_addr", bus.imem_addr_o, 32'hFFFF_FFFC);
        chk("wrap1_req",  bus.imem_req_o, 1);
        step();
        chk("wrap2_addr", bus.imem_addr_o, 32'h0);
        step();
        chk("wrap3_pc",   bus.pc_o, 32'hFFFF_FFFC);
        chk("wrap3_inst", bus.inst_o, rom(32'hFFFF_FFFC));
        step();
        chk("wrap4_pc",   bus.pc_o, 32'h0);
        chk("wrap4_inst", bus.inst_o, rom(32'h0));

        // Asynchronous reset mid-stream
        step();
        #2;
        p_reset = 1'b1;
        #1;
        chk("mrst_valid", bus.valid_o, 0);
        chk("mrst_req",   bus.imem_req_o, 0);
        chk("mrst_count", bus.count_o, 0);
        chk("mrst_addr",  bus.imem_addr_o, 32'h0);
        chk("mrst_pc",    bus.pc_o, 0);
        chk("mrst_inst",  bus.inst_o, 0);
        step();
        p_reset = 1'b0;
        #1;
        chk("rr0_req",  bus.imem_req_o, 1);
        chk("rr0_addr", bus.imem_addr_o, 32'h0);
        step();
        chk("rr1_valid", bus.valid_o, 0);
        step();
        chk("rr2_valid", bus.valid_o, 1);
        chk("rr2_pc",    bus.pc_o, 32'h0);
        chk("rr2_inst",  bus.inst_o, rom(32'h0));
        step();
        chk("rr3_pc", bus.pc_o, 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ifetch_queue.md
# ifetch_queue

Parametrised instruction-fetch front end that merges PC generation, instruction-memory request and a decoupling instruction queue into one block. It sits between the synchronous instruction ROM and decode. It issues one ROM request per cycle under credit control and buffers returned {pc, inst} pairs in a DEPTH-entry FIFO. On branch redirect it flushes queued and in-flight instructions, so decode stalls never lose or duplicate instructions.

## Interface
- XLEN, 32, PC/address width
- ILEN, 32, instruction width
- DEPTH, 4, queue entries; power of two, ≥2
- RESET_PC, 32'h0, first fetch address after reset
- m_clock  in  1  clock, rising edge
- p_reset  in  1  reset, asynchronous, active-high
- branch_taken_i  in  1  redirect request, one-cycle pulse or level
- branch_addr_i  in  XLEN  redirect target; bits [1:0] ignored (treated as 0)
- imem_req_o  out  1  ROM request valid this cycle
- imem_addr_o  out  XLEN  ROM address (= pc register)
- imem_data_i  in  ILEN  ROM data, valid the cycle after the request (1-cycle latency)
- valid_o  out  1  queue head valid
- ready_i  in  1  decode accepts head
- pc_o  out  XLEN  PC of head entry
- inst_o  out  ILEN  instruction of head entry
- count_o  out  $clog2(DEPTH+1)  current queue occupancy

## Operation
- State: pc, inflight (1 bit: request issued last cycle and not killed), FIFO (wr/rd pointers, count).
- pop = valid_o & ready_i. Head advances on pop.
- imem_req_o = !p_reset & !branch_taken_i & (count + inflight - pop < DEPTH). Combinational; never issue without a guaranteed free slot.
- On a request edge: pc ← pc + 4 (wraps modulo 2^XLEN); inflight ← 1. Otherwise inflight ← 0.
- Response: when inflight=1, {pc_of_req, imem_data_i} is written to the FIFO tail. The PC of the request is held in a shadow register.
- Branch (branch_taken_i=1 at an edge), highest priority: FIFO emptied (count←0, pointers reset), inflight←0 (response arriving next cycle discarded), pc ← {branch_addr_i[XLEN-1:2],2'b00}. A response arriving in the branch cycle is also discarded. No request is issued in the branch cycle.
- A pop and a branch in the same cycle: the pop counts as consumed by decode; the queue is then flushed.
- A push and a pop in the same cycle on a full queue are legal; count is unchanged.
- Reset mid-operation: all state returns to reset values immediately (async), and in-flight data is discarded.
- Reset values: pc=RESET_PC, inflight=0, count_o=0, valid_o=0, imem_req_o=0, imem_addr_o=RESET_PC, pc_o/inst_o=0 (storage cleared).

## Timing
- Request in cycle n → data on imem_data_i in n+1 → queued at end of n+1 → valid_o in n+2. Fetch-to-head latency is 2 cycles.
- First request: first cycle with p_reset low; first valid_o 2 cycles later, pc_o=RESET_PC.
- Branch asserted in cycle b → request at target in b+1 → valid_o with pc_o=target in b+3. No stale entry is visible from b+1 onward.
- With ready_i=1 continuously, throughput is 1 inst/cycle for any DEPTH≥2.
- With ready_i=0, the queue fills to exactly DEPTH and imem_req_o then stays low. Resuming ready_i=1 yields back-to-back sequential PCs with no gap or duplicate.
- pc_o/inst_o are stable while valid_o=1 and ready_i=0.

## Structure
- Shared package if_pkg: XLEN/ILEN defaults, RESET_PC default, fetch entry struct {pc, inst}, constant INST_BYTES=4.
- Sub-module ifq_fifo: synchronous DEPTH-entry FIFO (push, pop, flush, count, full/empty) with async reset. Occupancy uses a count register. Pointers are $clog2(DEPTH) bits and wrap naturally.
- Top holds the pc register, inflight/shadow-pc tracking, credit logic and branch priority.

## Test plan
- Reset release, ready_i=1, ROM returns addr-derived words: valid_o from cycle 2; pc_o sequence 0,4,8,12… one per cycle, inst_o matches ROM.
- ready_i=0 for 8 cycles with DEPTH=4: count_o saturates at 4, imem_req_o low; ready_i=1 again: pc_o continues with no skip or duplicate.
- branch_taken_i pulse at counter 5 with branch_addr_i=40: no pre-branch entry is delivered after the pulse; next valid_o has pc_o=40 exactly 3 cycles after the pulse, followed by 44, 48.
- Branch in the same cycle as a pop and with a full queue: count_o=0 next cycle, and the in-flight response is dropped.
- branch_addr_i=43: fetch resumes at 40. pc at 32'hFFFFFFFC increments to 0.
- p_reset asserted mid-stream: valid_o, imem_req_o and count_o drop immediately; after release fetch restarts at RESET_PC.
